// File: rtl/array_mult_pkg.sv
// Shared types and default sizing for the array multiplier issuer.
package array_mult_pkg;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_DEPTH   = 16;
  localparam int DEF_TIMEOUT = 64;
  localparam int DEF_IDX_W   = $clog2(DEF_DEPTH);

  typedef logic [DEF_WIDTH-1:0] word_t;
  typedef logic [DEF_IDX_W-1:0] idx_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } state_e;

endpackage

// File: rtl/array_mult_issuer_if.sv
// Operand/product bus between the issuer (master) and the pipelined multiplier (slave).
interface array_mult_issuer_if #(
  parameter int WIDTH = array_mult_pkg::DEF_WIDTH
) ();

  // mult_en qualifies mult_a/mult_b for exactly one cycle; there is no ready, the
  // multiplier takes a pair every cycle. mult_valid qualifies mult_p for one cycle,
  // and products return in the order their operand pairs were issued.
  logic             mult_en;
  logic [WIDTH-1:0] mult_a;
  logic [WIDTH-1:0] mult_b;
  logic             mult_valid;
  logic [WIDTH-1:0] mult_p;

  modport master (
    output mult_en, mult_a, mult_b,
    input  mult_valid, mult_p
  );

  modport slave (
    input  mult_en, mult_a, mult_b,
    output mult_valid, mult_p
  );

endinterface

// File: rtl/array_mult_regfile.sv
// DEPTH x WIDTH storage with one write port and one registered, enabled read port.
module array_mult_regfile
  import array_mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_d;
  logic [WIDTH-1:0] rdata_q;

  // Contents are deliberately not reset; only the read register is.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Same-cycle read of a location being written sees the old word.
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem[raddr];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/array_mult_issuer.sv
// Streams A[i]/B[i] pairs into a pipelined multiplier and collects the products in order into R.
module array_mult_issuer
  import array_mult_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wr_en,
  input  logic                     wr_sel,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH):0]   len,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data,
  output state_e                   dbg_state,
  array_mult_issuer_if.master      mif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  state_e          state_q, state_d;
  logic [LW-1:0]   len_q, len_d;
  logic [LW-1:0]   issue_idx_q, issue_idx_d;
  logic [LW-1:0]   res_idx_q, res_idx_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            error_q, error_d;
  logic            mult_en_q, mult_en_d;

  logic            ab_re;
  logic [AW-1:0]   ab_raddr;
  logic [LW-1:0]   issue_nxt;
  logic            res_we;
  logic            wr_ok;
  logic            len_ok;
  logic [WIDTH-1:0] a_rdata;
  logic [WIDTH-1:0] b_rdata;

  assign wr_ok     = wr_en & ~busy_q;
  assign len_ok    = (len != '0) && (len <= LW'(DEPTH));
  assign issue_nxt = issue_idx_q + LW'(1);

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    issue_idx_d = issue_idx_q;
    res_idx_d   = res_idx_q;
    timer_d     = timer_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    error_d     = error_q;
    mult_en_d   = 1'b0;
    ab_re       = 1'b0;
    ab_raddr    = issue_nxt[AW-1:0];
    res_we      = 1'b0;

    // The operand read is issued one cycle early so the registered read data lines
    // up with mult_en_q: issue_idx_q always names the pair currently on the bus.
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (len_ok) begin
            len_d       = len;
            error_d     = 1'b0;
            issue_idx_d = '0;
            res_idx_d   = '0;
            timer_d     = '0;
            busy_d      = 1'b1;
            mult_en_d   = 1'b1;
            ab_re       = 1'b1;
            ab_raddr    = '0;
            state_d     = ISSUE;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (issue_idx_q == len_q - LW'(1)) begin
          state_d = DRAIN;
        end else begin
          issue_idx_d = issue_nxt;
          mult_en_d   = 1'b1;
          ab_re       = 1'b1;
        end
      end
      DRAIN: begin
        if (res_idx_q == len_q) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = FINISH;
        end else if (timer_q == TW'(TIMEOUT)) begin
          error_d = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = FINISH;
        end else if (mif.mult_valid) begin
          timer_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Products beyond len indicate a misbehaving multiplier; they are dropped.
    if ((state_q == ISSUE || state_q == DRAIN) && mif.mult_valid) begin
      if (res_idx_q == len_q) begin
        error_d = 1'b1;
      end else begin
        res_we    = 1'b1;
        res_idx_d = res_idx_q + LW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      len_q       <= '0;
      issue_idx_q <= '0;
      res_idx_q   <= '0;
      timer_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      mult_en_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      issue_idx_q <= issue_idx_d;
      res_idx_q   <= res_idx_d;
      timer_q     <= timer_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      mult_en_q   <= mult_en_d;
    end
  end

  array_mult_regfile #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram_a (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (wr_ok & ~wr_sel),
    .waddr   (wr_addr),
    .wdata   (wr_data),
    .re      (ab_re),
    .raddr   (ab_raddr),
    .rdata   (a_rdata)
  );

  array_mult_regfile #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram_b (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (wr_ok & wr_sel),
    .waddr   (wr_addr),
    .wdata   (wr_data),
    .re      (ab_re),
    .raddr   (ab_raddr),
    .rdata   (b_rdata)
  );

  array_mult_regfile #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram_r (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (res_we),
    .waddr   (res_idx_q[AW-1:0]),
    .wdata   (mif.mult_p),
    .re      (1'b1),
    .raddr   (rd_addr),
    .rdata   (rd_data)
  );

  assign mif.mult_en = mult_en_q;
  assign mif.mult_a  = a_rdata;
  assign mif.mult_b  = b_rdata;
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_array_mult_issuer.sv
// Bench for array_mult_issuer: table-driven runs, hand-written corner sequences and random runs
// against a pipelined multiplier model and an array-level result model.
module tb_array_mult_issuer;
  import array_mult_pkg::*;

  localparam int W  = 32;
  localparam int D  = 16;
  localparam int AW = 4;
  localparam int LW = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset_n, wr_en, wr_sel, start, busy, done, error;
  logic [AW-1:0]  wr_addr, rd_addr;
  logic [W-1:0]   wr_data, rd_data;
  logic [LW-1:0]  len;
  state_e         dbg_state;

  array_mult_issuer_if #(.WIDTH(W)) mif ();

  array_mult_issuer #(.WIDTH(W), .DEPTH(D), .TIMEOUT(64)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_en     (wr_en),
    .wr_sel    (wr_sel),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .len       (len),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .dbg_state (dbg_state),
    .mif       (mif)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- multiplier model: lat_sel+1 register stages ----------------
  logic           mdl_rst;
  logic           pv [8];
  logic [W-1:0]   pp [8];
  logic [2:0]     lat_sel;
  logic           drop_en;
  int             drop_at;
  int             issue_total = 0;

  always @(posedge clk) begin
    if (mdl_rst) begin
      for (int i = 0; i < 8; i++) begin
        pv[i] <= 1'b0;
        pp[i] <= '0;
      end
    end else begin
      pv[0] <= mif.mult_en && !(drop_en && issue_total == drop_at);
      pp[0] <= mif.mult_a * mif.mult_b;
      for (int i = 1; i < 8; i++) begin
        pv[i] <= pv[i-1];
        pp[i] <= pp[i-1];
      end
    end
  end

  assign mif.mult_valid = pv[lat_sel];
  assign mif.mult_p     = pp[lat_sel];

  // ---------------- reference model and scoreboard ----------------
  logic [W-1:0]   a_m [D];
  logic [W-1:0]   b_m [D];
  logic [W-1:0]   r_model [D];
  bit             r_valid [D];
  logic [2*W-1:0] pair_q [$];
  logic [W-1:0]   exp_q [$];
  int             run_base, run_t0;

  always @(negedge clk) begin
    if (mif.mult_en) begin
      issue_total = issue_total + 1;
      chk("issue_expected", 64'(pair_q.size() != 0), 64'd1);
      if (pair_q.size() != 0) chk("issue_pair", {mif.mult_a, mif.mult_b}, pair_q.pop_front());
    end
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic write_op(input logic sel, input int addr, input logic [W-1:0] d);
    wr_en = 1'b1; wr_sel = sel; wr_addr = AW'(addr); wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic load_ops(input int n, input bit fixed_ops);
    for (int i = 0; i < n; i++) begin
      a_m[i] = fixed_ops ? W'(i + 1) : W'($urandom);
      b_m[i] = fixed_ops ? W'(i + 5) : W'($urandom);
      write_op(1'b0, i, a_m[i]);
      write_op(1'b1, i, b_m[i]);
    end
  endtask

  task automatic launch(input int n, input int lat);
    bit ok;
    ok = (n >= 1) && (n <= D);
    lat_sel = 3'(lat - 1);
    if (ok) for (int i = 0; i < n; i++) pair_q.push_back({a_m[i], b_m[i]});
    run_base = issue_total;
    start = 1'b1; len = LW'(n); run_t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    if (ok) chk("busy_after_start", busy, 1);
  endtask

  task automatic wait_done(input int n, input logic exp_err, input int exp_cyc);
    bit seen;
    int meas;
    seen = 0; meas = 0;
    for (int k = 0; k < 300 && !seen; k++) begin
      if (done) begin
        seen = 1; meas = cyc - run_t0;
      end else begin
        @(negedge clk);
      end
    end
    chk("done_seen", 64'(seen), 64'd1);
    if (seen) begin
      if (exp_cyc != 0) chk("done_latency", 64'(meas), 64'(exp_cyc));
      chk("busy_at_done", busy, 0);
      chk("error_at_done", error, exp_err);
      chk("issue_count", 64'(issue_total - run_base), 64'(n));
      chk("pairs_consumed", 64'(pair_q.size()), 64'd0);
      @(negedge clk);
      chk("done_one_cycle", done, 0);
    end
    repeat (12) @(negedge clk);
  endtask

  task automatic check_reject();
    bit any_busy, any_done;
    any_busy = 0; any_done = 0;
    for (int k = 0; k < 10; k++) begin
      any_busy |= busy;
      any_done |= done;
      @(negedge clk);
    end
    chk("reject_busy", 64'(any_busy), 64'd0);
    chk("reject_done", 64'(any_done), 64'd0);
    chk("reject_error", error, 1);
    chk("reject_issues", 64'(issue_total - run_base), 64'd0);
  endtask

  task automatic commit_r(input int n, input bit skip_last);
    for (int i = 0; i < n - (skip_last ? 1 : 0); i++) begin
      r_model[i] = a_m[i] * b_m[i];
      r_valid[i] = 1'b1;
    end
  endtask

  task automatic read_check(input int n);
    for (int i = 0; i < n; i++) begin
      if (r_valid[i]) begin
        exp_q.push_back(r_model[i]);
        rd_addr = AW'(i);
        @(negedge clk);
        chk($sformatf("result_word[%0d]", i), rd_data, exp_q.pop_front());
      end
    end
  endtask

  // ---------------- stimulus table ----------------
  typedef struct {
    int   n;
    int   lat;
    bit   fixed_ops;
    logic exp_err;
    int   exp_cyc;
  } vec_t;

  vec_t vt [7];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{n: 4,  lat: 3, fixed_ops: 1, exp_err: 1'b0, exp_cyc: 9};
    vt[1] = '{n: 16, lat: 5, fixed_ops: 0, exp_err: 1'b0, exp_cyc: 23};
    vt[2] = '{n: 0,  lat: 3, fixed_ops: 0, exp_err: 1'b1, exp_cyc: 0};
    vt[3] = '{n: 17, lat: 3, fixed_ops: 0, exp_err: 1'b1, exp_cyc: 0};
    vt[4] = '{n: 1,  lat: 1, fixed_ops: 0, exp_err: 1'b0, exp_cyc: 4};
    vt[5] = '{n: 7,  lat: 2, fixed_ops: 0, exp_err: 1'b0, exp_cyc: 11};
    vt[6] = '{n: 16, lat: 1, fixed_ops: 0, exp_err: 1'b0, exp_cyc: 19};

    for (int i = 0; i < D; i++) r_valid[i] = 1'b0;
    reset_n = 1'b0; mdl_rst = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; len = '0; rd_addr = '0; lat_sel = '0; drop_en = 1'b0; drop_at = -1;
    repeat (3) @(negedge clk);

    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_mult_en", mif.mult_en, 0);
    chk("rst_mult_a", mif.mult_a, 0);
    chk("rst_mult_b", mif.mult_b, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_state", dbg_state, IDLE);
    reset_n = 1'b1; mdl_rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 7; v++) begin
      if (vt[v].exp_cyc != 0) begin
        load_ops(vt[v].n, vt[v].fixed_ops);
        launch(vt[v].n, vt[v].lat);
        wait_done(vt[v].n, vt[v].exp_err, vt[v].exp_cyc);
        commit_r(vt[v].n, 1'b0);
        read_check(vt[v].n);
      end else begin
        launch(vt[v].n, vt[v].lat);
        check_reject();
      end
    end

    // start and operand writes during a run must not disturb it
    load_ops(8, 1'b0);
    launch(8, 4);
    for (int k = 0; k < 3; k++) begin
      start = 1'b1; len = LW'(3);
      wr_en = 1'b1; wr_sel = 1'($urandom_range(0, 1));
      wr_addr = AW'($urandom_range(0, 7)); wr_data = W'($urandom);
      @(negedge clk);
    end
    start = 1'b0; wr_en = 1'b0;
    wait_done(8, 1'b0, 14);
    commit_r(8, 1'b0);
    read_check(8);
    launch(8, 2);
    wait_done(8, 1'b0, 12);

    // last product never returns: timeout path
    load_ops(2, 1'b0);
    drop_en = 1'b1; drop_at = issue_total + 2;
    launch(2, 3);
    wait_done(2, 1'b1, 0);
    drop_en = 1'b0;
    commit_r(2, 1'b1);
    read_check(2);

    // random runs
    for (int r = 0; r < 5; r++) begin
      int n, lat;
      n   = $urandom_range(1, D);
      lat = $urandom_range(1, 6);
      load_ops(n, 1'b0);
      launch(n, lat);
      wait_done(n, 1'b0, n + lat + 2);
      commit_r(n, 1'b0);
      read_check(n);
    end

    // reset in the second issue cycle; late products must be ignored
    launch(8, 3);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_mult_en", mif.mult_en, 0);
    chk("midrst_state", dbg_state, IDLE);
    reset_n = 1'b1;
    pair_q.delete();
    repeat (12) @(negedge clk);
    read_check(D);
    launch(1, 3);
    wait_done(1, 1'b0, 6);
    commit_r(1, 1'b0);
    read_check(1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/array_mult_issuer.md
Name: array_mult_issuer

Overview:
- Initiator-side sequencer for the array multiplier datapath.
- Holds two operand arrays loaded by a host, streams element pairs into the multiplier's operand port, collects the returned products in order into a result array, then signals completion.
- Sits between the host/IK control logic and array_mult. It drives array_mult's inputs and consumes its outputs.

Parameters:
- WIDTH, 32, operand/product word width (fixed-point, product already truncated by multiplier)
- DEPTH, 16, maximum array length (power of two)
- TIMEOUT, 64, cycles without a returned product before error in DRAIN

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- wr_en  in  1  host write strobe for operand arrays
- wr_sel  in  1  0 = array A, 1 = array B
- wr_addr  in  $clog2(DEPTH)  operand write index
- wr_data  in  WIDTH  operand write data
- len  in  $clog2(DEPTH)+1  number of elements, sampled at start
- start  in  1  begin run (pulse)
- busy  out  1  run in progress
- done  out  1  one-cycle completion pulse
- error  out  1  sticky timeout/overflow flag, cleared by next accepted start
- mult_en  out  1  operand pair valid to multiplier
- mult_a  out  WIDTH  operand A
- mult_b  out  WIDTH  operand B
- mult_valid  in  1  product valid from multiplier
- mult_p  in  WIDTH  product
- rd_addr  in  $clog2(DEPTH)  host result read index
- rd_data  out  WIDTH  result word, registered (1-cycle read latency)

Behaviour:
- Reset (reset_n low at clk edge): state IDLE; busy, done, error, mult_en = 0; mult_a, mult_b, rd_data = 0; counters = 0. Operand/result storage is not cleared.
- States: IDLE, ISSUE, DRAIN, FINISH.
- IDLE:
  - start=1 with len in 1..DEPTH: latch len, clear error, clear issue_idx, res_idx and timer, go to ISSUE, busy=1 next cycle.
  - start=1 with len=0 or len>DEPTH: set error, stay IDLE, no done.
- ISSUE:
  - Each cycle: mult_en=1, mult_a=A[issue_idx], mult_b=B[issue_idx], issue_idx++. One pair per cycle with no stalls; the multiplier is fully pipelined.
  - After the pair with index len-1 is issued, go to DRAIN.
- Result capture, active in ISSUE and DRAIN:
  - mult_valid=1 writes mult_p to R[res_idx] and increments res_idx.
  - mult_valid in IDLE or FINISH is ignored.
  - If mult_valid=1 when res_idx==len: set error and discard the product.
- DRAIN:
  - mult_en=0. Timer increments each cycle without mult_valid and resets on mult_valid.
  - res_idx==len: go to FINISH.
  - Timer==TIMEOUT: set error and go to FINISH.
- FINISH: done=1 for exactly one cycle, busy=0, return to IDLE.
- Results may complete during ISSUE (multiplier latency < len). The block then passes through DRAIN for one cycle, giving a fixed 1-cycle DRAIN minimum.
- Latency for len=N and multiplier latency L: done asserted N+L+2 cycles after the start cycle, provided L < TIMEOUT.
- start while busy: ignored.
- wr_en while busy: write is ignored, operands stay stable.
- rd_addr reads are allowed anytime. Reading an index during the cycle it is written returns the old value.
- reset_n low mid-run: immediate return to IDLE. Later in-flight mult_valid is ignored.

Decomposition:
- Package array_mult_pkg:
  - word_t (logic [WIDTH-1:0])
  - idx_t
  - state enum (IDLE, ISSUE, DRAIN, FINISH)
  - DEPTH and TIMEOUT defaults
- Sub-module array_mult_regfile: DEPTH×WIDTH storage, one write port and one registered read port. Instantiated three times: A and B read by issue_idx, R read by rd_addr.
- FSM, counters and timer stay in the top.

Test Plan:
- Load A={1,2,3,4}, B={5,6,7,8}, len=4, multiplier L=3, start:
  - mult_en is high 4 consecutive cycles with pairs (1,5)..(4,8).
  - done fires at cycle 9 after start.
  - R reads {5,12,21,32}; error=0.
- len=16 with full random operands, L=5:
  - 16 back-to-back issues.
  - R matches A[i]*B[i] truncated to WIDTH.
  - done at cycle 23.
- len=0 start → error=1, busy stays 0, no done, no mult_en.
- Model drops the last product, len=2 → timer hits 64 in DRAIN, error=1, done pulses, R[0] valid.
- Deassert reset_n at the second ISSUE cycle:
  - Next cycle busy=0 and mult_en=0.
  - Late mult_valid pulses don't change R.
  - A new start with len=1 completes cleanly.
- start and wr_en asserted during a run → no effect. Operands seen on mult_a/mult_b remain the pre-start values.
